// File: rtl/pc_seq_unit_pkg.sv
// Shared definitions for the PC sequencing unit: next-PC source encoding,
// instruction step and J-type field width.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } next_sel_e;

    localparam int PC_STEP   = 4;
    localparam int J_INDEX_W = 26;

    // Fixed priority: register jump beats J-type, which beats a taken branch.
    function automatic next_sel_e select_next(input logic jr_req,
                                              input logic j_req,
                                              input logic br_req);
        if (jr_req) begin
            return SEL_JR;
        end
        if (j_req) begin
            return SEL_J;
        end
        if (br_req) begin
            return SEL_BR;
        end
        return SEL_SEQ;
    endfunction

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is a no-op so the caller can flag it.
module ras_stack
    import pc_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   count_reg;

    // Storage carries no reset; empty gates every use of top.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_reg] <= push_data;
        end
    end

    // The pointer wraps modulo RAS_DEPTH, which gives the overwrite-oldest
    // behaviour for free; only the occupancy count saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (count_reg != CW'(RAS_DEPTH)) begin
                count_reg <= count_reg + CW'(1);
            end
        end else if (pop && (count_reg != '0)) begin
            ptr_reg   <= ptr_reg - PW'(1);
            count_reg <= count_reg - CW'(1);
        end
    end

    assign top_idx = ptr_reg - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(RAS_DEPTH));

endmodule

// File: rtl/pc_seq_unit.sv
// Architectural PC register with prioritised next-PC select, a one-entry
// redirect latch that survives stalls, and an advisory return-address stack.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [XLEN-1:0]      imm,
    input  logic                 jmp,
    input  logic                 jal,
    input  logic [J_INDEX_W-1:0] j_index,
    input  logic                 jr,
    input  logic                 jr_ret,
    input  logic [XLEN-1:0]      jr_target,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_plus4,
    output logic [XLEN-1:0]      branch_pc,
    output logic [XLEN-1:0]      jmp_pc,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ret_mispredict,
    output logic                 misaligned
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pend_pc_reg;
    logic            pend_valid_reg;
    logic            ret_mispredict_reg;

    next_sel_e       sel;
    logic [XLEN-1:0] target_next;
    logic            redirect;
    logic            accept;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ret_mispredict_next;

    assign pc_plus4  = pc_reg + XLEN'(PC_STEP);
    assign branch_pc = pc_plus4 + (imm << 2);
    assign jmp_pc    = {pc_reg[XLEN-1:28], j_index, 2'b00};

    assign redirect = jr | jal | jmp | br_taken;
    // Inputs only take architectural effect when nothing is held back.
    assign accept   = !stall && !pend_valid_reg;

    always_comb begin
        sel         = select_next(jr, jal | jmp, br_taken);
        target_next = pc_plus4;
        case (sel)
            SEL_JR:  target_next = jr_target;
            SEL_J:   target_next = jmp_pc;
            SEL_BR:  target_next = branch_pc;
            default: target_next = pc_plus4;
        endcase
    end

    // jr outranks jal, so a simultaneous jal must not leave a stale link.
    assign ras_push = accept && jal && !jr;
    assign ras_pop  = accept && jr && jr_ret;

    assign ret_mispredict_next = ras_pop && (ras_empty || (ras_top != jr_target));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg             <= RESET_PC;
            pend_pc_reg        <= '0;
            pend_valid_reg     <= 1'b0;
            ret_mispredict_reg <= 1'b0;
        end else begin
            ret_mispredict_reg <= ret_mispredict_next;
            if (stall) begin
                if (redirect && !pend_valid_reg) begin
                    pend_pc_reg    <= target_next;
                    pend_valid_reg <= 1'b1;
                end
            end else if (pend_valid_reg) begin
                pc_reg         <= pend_pc_reg;
                pend_valid_reg <= 1'b0;
            end else begin
                pc_reg <= target_next;
            end
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc             = pc_reg;
    assign ret_mispredict = ret_mispredict_reg;
    assign misaligned     = jr && (jr_target[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: the driver pushes model predictions,
// a monitor pops and compares them against the DUT each cycle.
module tb_pc_seq_unit;

    localparam int          XLEN    = 32;
    localparam logic [31:0] RST_VEC = 32'hBFC0_0000;
    localparam int          RD      = 4;

    logic        clk = 1'b0;
    logic        rst_n, stall, br_taken, jmp, jal, jr, jr_ret;
    logic [31:0] imm, jr_target;
    logic [25:0] j_index;
    logic [31:0] pc, pc_plus4, branch_pc, jmp_pc;
    logic        ras_empty, ras_full, ret_mispredict, misaligned;

    always #5 clk = ~clk;

    pc_seq_unit #(.XLEN(XLEN), .RESET_PC(RST_VEC), .RAS_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .imm(imm),
        .jmp(jmp), .jal(jal), .j_index(j_index), .jr(jr), .jr_ret(jr_ret),
        .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4), .branch_pc(branch_pc),
        .jmp_pc(jmp_pc), .ras_empty(ras_empty), .ras_full(ras_full),
        .ret_mispredict(ret_mispredict), .misaligned(misaligned)
    );

    typedef struct {
        logic [31:0] pc;
        logic        rm;
        logic        empty;
        logic        full;
    } reg_exp_t;

    typedef struct {
        logic [31:0] p4;
        logic [31:0] bp;
        logic [31:0] jp;
        logic        mis;
    } comb_exp_t;

    reg_exp_t  exp_q[$];
    comb_exp_t cexp_q[$];

    // Reference model state: PC, one pending redirect, RAS as a bounded queue.
    logic [31:0] m_pc = RST_VEC;
    logic        m_pend_v = 1'b0;
    logic [31:0] m_pend_pc = '0;
    logic        m_rm = 1'b0;
    logic [31:0] m_ras[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    task automatic clear();
        stall = 0; br_taken = 0; jmp = 0; jal = 0; jr = 0; jr_ret = 0;
        imm = '0; j_index = '0; jr_target = '0;
    endtask

    // Apply the inputs already on the pins for one clock and predict the result.
    task automatic step();
        logic [31:0] p4, bp, jp, tgt, top;
        reg_exp_t    re;
        comb_exp_t   ce;
        #1;
        p4 = m_pc + 32'd4;
        bp = p4 + (imm << 2);
        jp = {m_pc[31:28], j_index, 2'b00};
        ce.p4 = p4; ce.bp = bp; ce.jp = jp;
        ce.mis = jr && (jr_target[1:0] != 2'b00);
        cexp_q.push_back(ce);
        if (jr)               tgt = jr_target;
        else if (jal || jmp)  tgt = jp;
        else if (br_taken)    tgt = bp;
        else                  tgt = p4;
        if (!rst_n) begin
            m_pc = RST_VEC; m_pend_v = 0; m_rm = 0; m_ras.delete();
        end else if (stall) begin
            m_rm = 0;
            if ((jr || jal || jmp || br_taken) && !m_pend_v) begin
                m_pend_v = 1; m_pend_pc = tgt;
            end
        end else if (m_pend_v) begin
            m_pc = m_pend_pc; m_pend_v = 0; m_rm = 0;
        end else begin
            m_rm = 0;
            if (jr && jr_ret) begin
                if (m_ras.size() == 0) begin
                    m_rm = 1;
                end else begin
                    top  = m_ras.pop_back();
                    m_rm = (top != jr_target);
                end
            end else if (jal && !jr) begin
                m_ras.push_back(p4);
                if (m_ras.size() > RD) void'(m_ras.pop_front());
            end
            m_pc = tgt;
        end
        re.pc = m_pc; re.rm = m_rm;
        re.empty = (m_ras.size() == 0);
        re.full  = (m_ras.size() == RD);
        exp_q.push_back(re);
        @(negedge clk);
    endtask

    task automatic goto(input logic [31:0] addr);
        clear(); jr = 1; jr_target = addr; step(); clear();
    endtask

    // Driver: directed scenarios followed by a randomized run.
    initial begin
        logic [31:0] tmp;
        rst_n = 0; clear();
        @(negedge clk);
        step(); step();
        rst_n = 1; step(); step(); step();
        goto(32'h0000_1000); br_taken = 1; imm = 32'hFFFF_FFFE; step(); clear();
        goto(32'h3000_0000); jmp = 1; j_index = 26'h0000040; step();
        jmp = 1; br_taken = 1; imm = 32'd7; j_index = 26'h0000080; step(); clear();
        goto(32'h0000_0100);
        stall = 1; br_taken = 1; imm = 32'd4; step(); clear();
        stall = 1; jr = 1; jr_target = 32'h0000_9000; step(); clear();
        stall = 1; step();
        stall = 0; jr = 1; jr_target = 32'h0000_9000; step(); clear(); step();
        goto(32'h0000_0200); jal = 1; j_index = 26'h0000100; step(); clear(); step();
        jr = 1; jr_ret = 1; jr_target = 32'h0000_0204; step(); clear(); step();
        goto(32'h0000_0200); jal = 1; j_index = 26'h0000100; step(); clear();
        jr = 1; jr_ret = 1; jr_target = 32'h0000_0208; step(); clear(); step(); step();
        for (int i = 0; i < 5; i++) begin
            jal = 1; j_index = 26'(32'h10 + i * 8); step(); clear();
        end
        for (int i = 0; i < 5; i++) begin
            jr = 1; jr_ret = 1;
            jr_target = (m_ras.size() != 0) ? m_ras[$] : 32'h0000_0500;
            step(); clear();
        end
        goto(32'hFFFF_FFFC); step();
        jr = 1; jr_target = 32'h0000_0402; step(); clear(); step();
        stall = 1; br_taken = 1; imm = 32'd8; step();
        rst_n = 0; step(); rst_n = 1; clear(); step(); step();
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 3) == 0);
            jmp      = ($urandom_range(0, 5) == 0);
            jal      = ($urandom_range(0, 4) == 0);
            jr       = ($urandom_range(0, 4) == 0);
            jr_ret   = ($urandom_range(0, 1) == 1);
            imm      = 32'($urandom_range(0, 63)) - 32'd32;
            j_index  = 26'($urandom);
            tmp      = $urandom;
            case ($urandom_range(0, 3))
                0:       jr_target = tmp;
                1:       jr_target = (m_ras.size() != 0) ? m_ras[$] : {tmp[31:2], 2'b00};
                default: jr_target = {tmp[31:2], 2'b00};
            endcase
            step();
        end
        clear(); rst_n = 1; step();
        done = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: registered outputs after each rising edge, combinational
    // outputs once the driver has settled the inputs.
    initial begin
        reg_exp_t  e;
        comb_exp_t c;
        int        cycles = 0;
        bit        timed_out = 0;
        while (!(done && exp_q.size() == 0 && cexp_q.size() == 0)) begin
            if (cycles >= 20000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("ret_mispredict", 32'(ret_mispredict), 32'(e.rm));
                chk("ras_empty", 32'(ras_empty), 32'(e.empty));
                chk("ras_full", 32'(ras_full), 32'(e.full));
                $display("cyc %0d pc=%h rm=%b empty=%b full=%b", cycles, pc,
                         ret_mispredict, ras_empty, ras_full);
            end
            @(negedge clk); #2;
            if (cexp_q.size() != 0) begin
                c = cexp_q.pop_front();
                chk("pc_plus4", pc_plus4, c.p4);
                chk("branch_pc", branch_pc, c.bp);
                chk("jmp_pc", jmp_pc, c.jp);
                chk("misaligned", 32'(misaligned), 32'(c.mis));
            end
            cycles++;
        end
        if (timed_out) begin
            n_bad++;
            $display("FAIL timeout: got %0d cycles expected completion", cycles);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
